flash_sample_scheduler: RTL and testbench

Sequences 32-bit word reads from the on-board flash over an Avalon-MM read port. Splits each word into two 16-bit audio samples and hands one sample to the audio path per sample_tick. Sits between the clock-divider tick generator and the audio codec interface. Owns the playback address: forward/reverse direction, wrap-around at the song bounds, and restart.

---
 rtl/flash_player_pkg.sv | 23 ++
 rtl/flash_addr_counter.sv | 50 +++++
 rtl/flash_sample_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_flash_sample_scheduler.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_player_pkg.sv
// Shared types and defaults for the flash sample player.
package flash_player_pkg;

    localparam int FLASH_ADDR_W = 23;
    localparam int SAMPLE_W     = 16;

    localparam logic [FLASH_ADDR_W-1:0] SONG_START = 23'h000000;
    localparam logic [FLASH_ADDR_W-1:0] SONG_END   = 23'h07FFFF;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        SLOT0,
        SLOT1,
        ADVANCE
    } state_t;

    function automatic logic [SAMPLE_W-1:0] pick_half(input logic [31:0] word, input logic high);
        return high ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/flash_addr_counter.sv
// Up/down word-address counter that wraps between LO and HI inclusive.
// o_wrap pulses in the same cycle the wrapped value appears on o_count.
module flash_addr_counter #(
    parameter int           W  = 23,
    parameter logic [W-1:0] LO = '0,
    parameter logic [W-1:0] HI = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_wrap
);

    logic [W-1:0] r_count;
    logic         r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= LO;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_inc) begin
                if (r_count == HI) begin
                    r_count <= LO;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (i_dec) begin
                if (r_count == LO) begin
                    r_count <= HI;
                    r_wrap  <= 1'b1;
                end else begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/flash_sample_scheduler.sv
// Fetches 32-bit flash words over Avalon-MM and plays them out as two 16-bit samples per word.
//
// state     | meaning
// IDLE      | after reset, waiting for play
// REQ       | flash_read asserted, waiting for waitrequest low
// WAIT_DATA | read accepted, waiting for readdatavalid
// SLOT0     | word buffered, first half not yet played
// SLOT1     | first half played, second half pending
// ADVANCE   | step address in the current direction, then fetch again
module flash_sample_scheduler
    import flash_player_pkg::*;
#(
    parameter int                ADDR_W     = FLASH_ADDR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = SONG_START,
    parameter logic [ADDR_W-1:0] END_ADDR   = SONG_END
) (
    input  logic                clk,
    input  logic                reset_all_n,
    input  logic                play,
    input  logic                reverse,
    input  logic                restart,
    input  logic                sample_tick,
    output logic [ADDR_W-1:0]   flash_address,
    output logic                flash_read,
    output logic [3:0]          flash_byteenable,
    input  logic                flash_waitrequest,
    input  logic [31:0]         flash_readdata,
    input  logic                flash_readdatavalid,
    output logic [SAMPLE_W-1:0] audio_data,
    output logic                audio_valid,
    output logic                underrun,
    output logic                song_wrap
);

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_word;
    logic                r_first_half;
    logic                r_restart_pending;
    logic [SAMPLE_W-1:0] r_audio_data;
    logic                r_audio_valid;
    logic                r_underrun;

    logic                w_tick_play;
    logic                w_flash_read;
    logic                w_accept;
    logic                w_underrun;
    logic                w_latch;
    logic                w_load;
    logic                w_inc;
    logic                w_dec;
    logic                w_set_pend;
    logic                w_clr_pend;
    logic                w_take_high;
    logic [ADDR_W-1:0]   w_restart_addr;

    assign w_tick_play    = sample_tick & play;
    assign w_restart_addr = reverse ? END_ADDR : START_ADDR;

    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A returning word is discarded if a restart is pending or arrives with it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (play) w_next = REQ;
            REQ:       if (!flash_waitrequest) w_next = WAIT_DATA;
            WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    w_next = (r_restart_pending || restart) ? REQ : SLOT0;
                end
            end
            SLOT0: begin
                if (restart)          w_next = REQ;
                else if (w_tick_play) w_next = SLOT1;
            end
            SLOT1: begin
                if (restart)          w_next = REQ;
                else if (w_tick_play) w_next = ADVANCE;
            end
            ADVANCE:   w_next = REQ;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        w_flash_read = 1'b0;
        w_accept     = 1'b0;
        w_underrun   = 1'b0;
        w_latch      = 1'b0;
        w_load       = 1'b0;
        w_inc        = 1'b0;
        w_dec        = 1'b0;
        w_set_pend   = 1'b0;
        w_clr_pend   = 1'b0;
        case (r_state)
            IDLE: w_load = restart;
            REQ: begin
                w_flash_read = 1'b1;
                w_underrun   = w_tick_play;
                w_set_pend   = restart;
            end
            WAIT_DATA: begin
                w_underrun = w_tick_play;
                if (flash_readdatavalid) begin
                    if (r_restart_pending || restart) begin
                        w_load     = 1'b1;
                        w_clr_pend = 1'b1;
                    end else begin
                        w_latch = 1'b1;
                    end
                end else begin
                    w_set_pend = restart;
                end
            end
            SLOT0, SLOT1: begin
                w_accept = w_tick_play;
                w_load   = restart;
            end
            ADVANCE: begin
                w_underrun = w_tick_play;
                if (restart)      w_load = 1'b1;
                else if (reverse) w_dec  = 1'b1;
                else              w_inc  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_take_high = (r_state == SLOT0) ? r_first_half : ~r_first_half;

    always_ff @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            r_word            <= '0;
            r_first_half      <= 1'b0;
            r_restart_pending <= 1'b0;
            r_audio_data      <= '0;
            r_audio_valid     <= 1'b0;
            r_underrun        <= 1'b0;
        end else begin
            r_audio_valid <= w_accept;
            r_underrun    <= w_underrun;
            if (w_accept) begin
                r_audio_data <= pick_half(r_word, w_take_high);
            end
            if (w_latch) begin
                r_word       <= flash_readdata;
                r_first_half <= reverse;
            end
            if (w_clr_pend) begin
                r_restart_pending <= 1'b0;
            end else if (w_set_pend) begin
                r_restart_pending <= 1'b1;
            end
        end
    end

    flash_addr_counter #(
        .W  (ADDR_W),
        .LO (START_ADDR),
        .HI (END_ADDR)
    ) u_addr_counter (
        .clk        (clk),
        .rst_n      (reset_all_n),
        .i_load     (w_load),
        .i_load_val (w_restart_addr),
        .i_inc      (w_inc),
        .i_dec      (w_dec),
        .o_count    (flash_address),
        .o_wrap     (song_wrap)
    );

    assign flash_read       = w_flash_read;
    assign flash_byteenable = 4'hF;
    assign audio_data       = r_audio_data;
    assign audio_valid      = r_audio_valid;
    assign underrun         = r_underrun;

endmodule

// File: tb/tb_flash_sample_scheduler.sv
// Bench for flash_sample_scheduler: sample-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized play/tick/restart traffic.
module tb_flash_sample_scheduler;

    localparam logic [22:0] START = 23'h000000;
    localparam logic [22:0] ENDA  = 23'h07FFFF;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_SLOT = 3;
    localparam int PH_ADV  = 4;

    logic        clk = 1'b0;
    logic        reset_all_n = 1'b0;
    logic        play = 1'b0;
    logic        reverse = 1'b0;
    logic        restart = 1'b0;
    logic        sample_tick = 1'b0;
    logic        flash_waitrequest = 1'b0;
    logic [31:0] flash_readdata = 32'h0;
    logic        flash_readdatavalid = 1'b0;
    logic [22:0] flash_address;
    logic        flash_read;
    logic [3:0]  flash_byteenable;
    logic [15:0] audio_data;
    logic        audio_valid;
    logic        underrun;
    logic        song_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flash_sample_scheduler dut (
        .clk                 (clk),
        .reset_all_n         (reset_all_n),
        .play                (play),
        .reverse             (reverse),
        .restart             (restart),
        .sample_tick         (sample_tick),
        .flash_address       (flash_address),
        .flash_read          (flash_read),
        .flash_byteenable    (flash_byteenable),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdata      (flash_readdata),
        .flash_readdatavalid (flash_readdatavalid),
        .audio_data          (audio_data),
        .audio_valid         (audio_valid),
        .underrun            (underrun),
        .song_wrap           (song_wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: playback position, a queue of samples still to play,
    // and where the player is in the fetch/play/advance cycle.
    int          m_phase;
    logic [22:0] m_addr;
    logic        m_pend;
    logic        m_tp;
    logic [15:0] m_q[$];
    logic [15:0] e_data;
    logic        e_valid;
    logic        e_under;
    logic        e_wrap;

    function automatic logic [22:0] restart_target(input logic rev);
        return rev ? ENDA : START;
    endfunction

    always @(posedge clk or negedge reset_all_n) begin
        if (!reset_all_n) begin
            m_phase = PH_IDLE;
            m_addr  = START;
            m_pend  = 1'b0;
            m_q.delete();
            e_data  = 16'h0;
            e_valid = 1'b0;
            e_under = 1'b0;
            e_wrap  = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_under = 1'b0;
            e_wrap  = 1'b0;
            m_tp    = sample_tick && play;
            case (m_phase)
                PH_IDLE: begin
                    if (restart) m_addr = restart_target(reverse);
                    if (play) m_phase = PH_REQ;
                end
                PH_REQ: begin
                    e_under = m_tp;
                    if (restart) m_pend = 1'b1;
                    if (!flash_waitrequest) m_phase = PH_WAIT;
                end
                PH_WAIT: begin
                    e_under = m_tp;
                    if (flash_readdatavalid) begin
                        if (m_pend || restart) begin
                            m_pend  = 1'b0;
                            m_addr  = restart_target(reverse);
                            m_phase = PH_REQ;
                        end else begin
                            m_q.delete();
                            if (reverse) begin
                                m_q.push_back(flash_readdata[31:16]);
                                m_q.push_back(flash_readdata[15:0]);
                            end else begin
                                m_q.push_back(flash_readdata[15:0]);
                                m_q.push_back(flash_readdata[31:16]);
                            end
                            m_phase = PH_SLOT;
                        end
                    end else if (restart) begin
                        m_pend = 1'b1;
                    end
                end
                PH_SLOT: begin
                    if (m_tp) begin
                        e_data  = m_q.pop_front();
                        e_valid = 1'b1;
                    end
                    if (restart) begin
                        m_q.delete();
                        m_addr  = restart_target(reverse);
                        m_phase = PH_REQ;
                    end else if (m_q.size() == 0) begin
                        m_phase = PH_ADV;
                    end
                end
                default: begin
                    e_under = m_tp;
                    if (restart) begin
                        m_addr = restart_target(reverse);
                    end else if (!reverse) begin
                        if (m_addr == ENDA) begin m_addr = START; e_wrap = 1'b1; end
                        else m_addr = m_addr + 23'd1;
                    end else begin
                        if (m_addr == START) begin m_addr = ENDA; e_wrap = 1'b1; end
                        else m_addr = m_addr - 23'd1;
                    end
                    m_phase = PH_REQ;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset_all_n) begin
            chk("flash_address", 32'(flash_address), 32'(m_addr));
            chk("flash_read", 32'(flash_read), 32'(m_phase == PH_REQ));
            chk("flash_byteenable", 32'(flash_byteenable), 32'hF);
            chk("audio_data", 32'(audio_data), 32'(e_data));
            chk("audio_valid", 32'(audio_valid), 32'(e_valid));
            chk("underrun", 32'(underrun), 32'(e_under));
            chk("song_wrap", 32'(song_wrap), 32'(e_wrap));
        end
    end

    // Avalon slave: holds waitrequest for fix_wait cycles per request (random if <0),
    // returns data fix_lat cycles after acceptance (random 1..3 if <0).
    int          fix_wait = 3;
    int          fix_lat  = 2;
    logic        ovr_en   = 1'b1;
    logic [31:0] ovr_word = 32'hBBBB_AAAA;

    initial begin : responder
        int          wcnt;
        int          wtgt;
        int          lat;
        logic        prev_fr;
        logic        prev_wr;
        wcnt = 0; wtgt = 3; lat = 0; prev_fr = 1'b0; prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_all_n) begin
                lat = 0; wcnt = 0; prev_fr = 1'b0; prev_wr = 1'b0;
                wtgt = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
                flash_readdatavalid = 1'b0;
                flash_waitrequest   = 1'b0;
            end else begin
                flash_readdatavalid = 1'b0;
                flash_readdata      = $urandom;
                if (prev_fr && !prev_wr) begin
                    lat  = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 3));
                    wcnt = 0;
                    wtgt = (fix_wait >= 0) ? fix_wait : int'($urandom_range(0, 3));
                end
                if (lat > 0) begin
                    lat--;
                    if (lat == 0) begin
                        flash_readdatavalid = 1'b1;
                        flash_readdata      = ovr_en ? ovr_word : $urandom;
                    end
                end
                if (flash_read) begin
                    if (wcnt < wtgt) begin
                        flash_waitrequest = 1'b1;
                        wcnt++;
                    end else begin
                        flash_waitrequest = 1'b0;
                    end
                end else begin
                    flash_waitrequest = 1'($urandom_range(0, 1));
                end
                prev_fr = flash_read;
                prev_wr = flash_waitrequest;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic tick_once();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    initial begin : main
        int  n;
        int  vcount;
        bit  found;

        repeat (3) step();
        chk("rst_address", 32'(flash_address), 32'(START));
        chk("rst_read", 32'(flash_read), 32'h0);
        chk("rst_audio_data", 32'(audio_data), 32'h0);
        chk("rst_flags", {29'h0, audio_valid, underrun, song_wrap}, 32'h0);

        // forward play of 0xBBBBAAAA at address 0
        reset_all_n = 1'b1;
        play        = 1'b1;
        repeat (12) step();
        tick_once();
        chk("t1_valid0", 32'(audio_valid), 32'h1);
        chk("t1_data0", 32'(audio_data), 32'hAAAA);
        step();
        chk("t1_valid_pulse", 32'(audio_valid), 32'h0);
        tick_once();
        chk("t1_data1", 32'(audio_data), 32'hBBBB);
        step();
        chk("t1_next_read", 32'(flash_read), 32'h1);
        chk("t1_next_addr", 32'(flash_address), 32'h1);

        // restart from SLOT0 back to start, then play reverse across the start bound
        repeat (12) step();
        restart = 1'b1;
        step();
        restart  = 1'b0;
        reverse  = 1'b1;
        ovr_word = 32'h1234_5678;
        chk("t2_restart_addr", 32'(flash_address), 32'(START));
        chk("t2_restart_read", 32'(flash_read), 32'h1);
        repeat (12) step();
        tick_once();
        chk("t2_data0", 32'(audio_data), 32'h1234);
        tick_once();
        chk("t2_data1", 32'(audio_data), 32'h5678);
        step();
        chk("t2_wrap_addr", 32'(flash_address), 32'(ENDA));
        chk("t2_wrap", 32'(song_wrap), 32'h1);
        reverse = 1'b0;
        step();
        chk("t2_wrap_once", 32'(song_wrap), 32'h0);

        // forward across the end bound
        ovr_word = 32'h9999_8888;
        repeat (12) step();
        tick_once();
        chk("t3_data0", 32'(audio_data), 32'h8888);
        tick_once();
        chk("t3_data1", 32'(audio_data), 32'h9999);
        step();
        chk("t3_wrap_addr", 32'(flash_address), 32'(START));
        chk("t3_wrap", 32'(song_wrap), 32'h1);
        step();
        chk("t3_wrap_once", 32'(song_wrap), 32'h0);

        // tick while waiting for data
        ovr_word = 32'hCAFE_F00D;
        n = 0;
        while (flash_read && n < 20) begin step(); n++; end
        chk("t4_reach_wait", 32'(flash_read), 32'h0);
        tick_once();
        chk("t4_underrun", 32'(underrun), 32'h1);
        chk("t4_no_valid", 32'(audio_valid), 32'h0);
        chk("t4_data_held", 32'(audio_data), 32'h9999);
        step();
        chk("t4_underrun_pulse", 32'(underrun), 32'h0);
        repeat (2) step();
        tick_once();
        chk("t4_after_data", 32'(audio_data), 32'hF00D);

        // climb to 0x100, then restart while the read is stalled
        ovr_en = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            if (flash_address == 23'h100 && flash_read && flash_waitrequest) found = 1'b1;
            else begin
                sample_tick = 1'($urandom_range(0, 1));
                step();
            end
        end
        sample_tick = 1'b0;
        chk("t5_reach_0x100", 32'(found), 32'h1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("t5_read_held", 32'(flash_read), 32'h1);
        chk("t5_addr_held", 32'(flash_address), 32'h100);
        found  = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (audio_valid) vcount++;
            if (flash_read && flash_address == START) found = 1'b1;
            else step();
        end
        chk("t5_reread_start", 32'(found), 32'h1);
        chk("t5_no_audio", 32'(vcount), 32'h0);

        // async reset during WAIT_DATA at a non-zero address
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (flash_address == 23'h3 && flash_read) found = 1'b1;
            else begin
                sample_tick = 1'($urandom_range(0, 1));
                step();
            end
        end
        sample_tick = 1'b0;
        chk("t6_reach_addr3", 32'(found), 32'h1);
        n = 0;
        while (flash_read && n < 20) begin step(); n++; end
        chk("t6_in_wait", 32'(flash_read), 32'h0);
        reset_all_n = 1'b0;
        #1;
        chk("t6_rst_addr", 32'(flash_address), 32'(START));
        chk("t6_rst_read", 32'(flash_read), 32'h0);
        chk("t6_rst_data", 32'(audio_data), 32'h0);
        chk("t6_rst_flags", {29'h0, audio_valid, underrun, song_wrap}, 32'h0);
        repeat (3) step();
        reset_all_n = 1'b1;
        n = 0;
        while (!flash_read && n < 10) begin step(); n++; end
        chk("t6_first_read", 32'(flash_read), 32'h1);
        chk("t6_first_addr", 32'(flash_address), 32'(START));

        // restart in IDLE with reverse loads the end address
        reset_all_n = 1'b0;
        play        = 1'b0;
        step();
        reset_all_n = 1'b1;
        reverse     = 1'b1;
        repeat (2) step();
        chk("t7_idle_noread", 32'(flash_read), 32'h0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("t7_idle_restart", 32'(flash_address), 32'(ENDA));

        // randomized traffic
        fix_wait = -1;
        fix_lat  = -1;
        for (int i = 0; i < 3000; i++) begin
            play        = ($urandom_range(0, 9) != 0);
            sample_tick = ($urandom_range(0, 2) == 0);
            restart     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) reverse = ~reverse;
            step();
        end
        sample_tick = 1'b0;
        restart     = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
